// File: rtl/sqrt_result_pack.sv
// rtl/sqrt_result_pack.sv - FP16 square-root result packer: special/zero bypass, core launch, timeout, output hold
//
// Takes one operand from the special-value classifier. NaN/Inf and zero
// operands bypass the core and are packed directly. Normal and subnormal
// operands are latched and handed to the sqrt core. The packed FP16 result is
// then held on out_data until the downstream handshake completes.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_valid / in_ready           operand handshake (in_ready only in IDLE)
//   is_nan .. is_subnormal       classifier flags
//   sign_in, exp_in, mant_in     classifier-adjusted FP16 fields
//   core_start                   one-cycle launch pulse to the sqrt core
//   core_exp, core_mant, core_sub  operand held for the core while it runs
//   core_done, res_exp, res_mant core completion and result
//   out_valid, out_data          packed result {sign, exp, mant}
//   out_ready                    downstream accept
//   status[2:0]                  {timeout, special, invalid}; only present
//                                when SQRT_PACK_STATUS_EN is defined
module sqrt_result_pack #(
   parameter int unsigned TIMEOUT = 47
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        in_ready,
   input  logic        is_nan,
   input  logic        is_pinf,
   input  logic        is_ninf,
   input  logic        is_normal,
   input  logic        is_subnormal,
   input  logic        sign_in,
   input  logic [4:0]  exp_in,
   input  logic [9:0]  mant_in,
   output logic        core_start,
   output logic [4:0]  core_exp,
   output logic [9:0]  core_mant,
   output logic        core_sub,
   input  logic        core_done,
   input  logic [4:0]  res_exp,
   input  logic [9:0]  res_mant,
   output logic        out_valid,
   output logic [15:0] out_data,
   input  logic        out_ready
`ifdef SQRT_PACK_STATUS_EN
   ,
   output logic [2:0]  status
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CORE_WAIT = 2'd1,
      OUT_HOLD  = 2'd2
   } state_t;

   localparam logic [5:0]  TIMEOUT_CNT = 6'(TIMEOUT);
   localparam logic [15:0] QNAN        = 16'h7E00;

   state_t     state;
   logic [5:0] cnt;
   logic [5:0] cnt_next;
   logic       is_special;
   logic       is_finite;

   assign in_ready   = (state == IDLE);
   assign cnt_next   = cnt + 6'd1;
   assign is_special = is_nan | is_pinf | is_ninf;
   assign is_finite  = is_normal | is_subnormal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 6'd0;
         core_start <= 1'b0;
         core_exp   <= 5'd0;
         core_mant  <= 10'd0;
         core_sub   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= 16'd0;
`ifdef SQRT_PACK_STATUS_EN
         status     <= 3'b000;
`endif
      end else begin
         // core_start is a single-cycle pulse: only the accept branch sets it
         core_start <= 1'b0;
         case (state)
            IDLE: begin
               if (s_valid) begin
                  if (is_special) begin
                     out_data  <= {sign_in, exp_in, mant_in};
                     out_valid <= 1'b1;
                     state     <= OUT_HOLD;
`ifdef SQRT_PACK_STATUS_EN
                     // a negative operand comes out of the classifier as a signed NaN
                     status    <= {1'b0, 1'b1, is_nan & sign_in};
`endif
                  end else if (is_finite) begin
                     core_exp   <= exp_in;
                     core_mant  <= mant_in;
                     core_sub   <= is_subnormal;
                     core_start <= 1'b1;
                     cnt        <= 6'd0;
                     state      <= CORE_WAIT;
                  end else begin
                     // sqrt(+-0) = +-0
                     out_data  <= {sign_in, 15'd0};
                     out_valid <= 1'b1;
                     state     <= OUT_HOLD;
`ifdef SQRT_PACK_STATUS_EN
                     status    <= 3'b010;
`endif
                  end
               end
            end
            CORE_WAIT: begin
               // core_done wins even on the cycle the counter would expire
               if (core_done) begin
                  out_data  <= {1'b0, res_exp, res_mant};
                  out_valid <= 1'b1;
                  state     <= OUT_HOLD;
`ifdef SQRT_PACK_STATUS_EN
                  status    <= 3'b000;
`endif
               end else begin
                  cnt <= cnt_next;
                  if (cnt_next == TIMEOUT_CNT) begin
                     out_data  <= QNAN;
                     out_valid <= 1'b1;
                     state     <= OUT_HOLD;
`ifdef SQRT_PACK_STATUS_EN
                     status    <= 3'b101;
`endif
                  end
               end
            end
            OUT_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_result_pack.sv
// tb/tb_sqrt_result_pack.sv - self-checking bench for sqrt_result_pack
module tb_sqrt_result_pack;

   localparam int TO = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        in_ready;
   logic        is_nan, is_pinf, is_ninf, is_normal, is_subnormal;
   logic        sign_in;
   logic [4:0]  exp_in;
   logic [9:0]  mant_in;
   logic        core_start;
   logic [4:0]  core_exp;
   logic [9:0]  core_mant;
   logic        core_sub;
   logic        core_done;
   logic [4:0]  res_exp;
   logic [9:0]  res_mant;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
`ifdef SQRT_PACK_STATUS_EN
   logic [2:0]  status;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sqrt_result_pack #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .in_ready(in_ready),
      .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf),
      .is_normal(is_normal), .is_subnormal(is_subnormal),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
      .core_start(core_start), .core_exp(core_exp), .core_mant(core_mant),
      .core_sub(core_sub), .core_done(core_done), .res_exp(res_exp),
      .res_mant(res_mant), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready)
`ifdef SQRT_PACK_STATUS_EN
      , .status(status)
`endif
   );

   // Operand classes: 0 NaN, 1 +Inf, 2 -Inf, 3 zero, 4 normal, 5 subnormal
   function automatic logic [15:0] model_bypass(input int cls, input logic s,
                                                input logic [4:0] e, input logic [9:0] m);
      if (cls == 3) return {s, 15'd0};
      return {s, e, m};
   endfunction

   // Returns {timeout, special, invalid}
   function automatic logic [2:0] model_status(input int cls, input logic s, input logic timed_out);
      if (cls <= 3) return {1'b0, 1'b1, (cls == 0) && s};
      if (timed_out) return 3'b101;
      return 3'b000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input int cls, input logic s, input logic [4:0] e, input logic [9:0] m);
      s_valid      = 1'b1;
      is_nan       = (cls == 0);
      is_pinf      = (cls == 1);
      is_ninf      = (cls == 2);
      is_normal    = (cls == 4);
      is_subnormal = (cls == 5);
      sign_in      = s;
      exp_in       = e;
      mant_in      = m;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_op(1, 1'b0, 5'd31, 10'd0);
      core_done = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
      checks++; if ({core_exp, core_mant, core_sub} !== 16'd0) begin errors++; $display("FAIL reset_core_operand got=%h exp=0000", {core_exp, core_mant, core_sub}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef SQRT_PACK_STATUS_EN
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", status); end
`endif
      rst = 1'b0;
      s_valid = 1'b0;
      core_done = 1'b0;
   endtask

   task automatic test_pinf();
      drive_op(1, 1'b0, 5'd31, 10'd0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pinf_in_ready_before got=%b exp=1", in_ready); end
      step();
      s_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pinf_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 16'h7C00) begin errors++; $display("FAIL pinf_out_data got=%h exp=7c00", out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pinf_in_ready_hold got=%b exp=0", in_ready); end
`ifdef SQRT_PACK_STATUS_EN
      checks++; if (status !== 3'b010) begin errors++; $display("FAIL pinf_status got=%b exp=010", status); end
`endif
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL pinf_release got=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_neg_nan();
      drive_op(0, 1'b1, 5'd31, 10'h200);
      step();
      s_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hFE00) begin errors++; $display("FAIL negnan_out got=%b/%h exp=1/fe00", out_valid, out_data); end
`ifdef SQRT_PACK_STATUS_EN
      checks++; if (status !== 3'b011) begin errors++; $display("FAIL negnan_status got=%b exp=011", status); end
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_core_and_hold();
      logic early;
      early = 1'b0;
      drive_op(4, 1'b0, 5'd16, 10'd0);
      step();
      s_valid = 1'b0;
      checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL core_start_pulse got=%b exp=1", core_start); end
      checks++; if (core_exp !== 5'd16 || core_mant !== 10'd0 || core_sub !== 1'b0) begin errors++; $display("FAIL core_operand got=%0d/%h/%b exp=16/000/0", core_exp, core_mant, core_sub); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL core_in_ready got=%b exp=0", in_ready); end
      step();
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL core_start_once got=%b exp=0", core_start); end
      for (int k = 0; k < 3; k++) begin
         step();
         if (out_valid !== 1'b0 || core_start !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL core_quiet_wait got=1 exp=0"); end
      core_done = 1'b1;
      res_exp = 5'd15;
      res_mant = 10'h1A8;
      step();
      core_done = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h3DA8) begin errors++; $display("FAIL core_result got=%b/%h exp=1/3da8", out_valid, out_data); end
      // Back-pressure: result must stay put while out_ready is low
      for (int k = 0; k < 4; k++) begin
         res_exp = 5'($urandom);
         res_mant = 10'($urandom);
         step();
         checks++; if (out_valid !== 1'b1 || out_data !== 16'h3DA8 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_stable got=%b/%h/%b exp=1/3da8/0", out_valid, out_data, in_ready); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_timeout();
      int lat;
      lat = 0;
      drive_op(5, 1'b0, 5'd0, 10'h155);
      step();
      s_valid = 1'b0;
      checks++; if (core_sub !== 1'b1 || core_mant !== 10'h155) begin errors++; $display("FAIL sub_operand got=%b/%h exp=1/155", core_sub, core_mant); end
      for (int k = 1; k <= TO + 3 && lat == 0; k++) begin
         step();
         if (out_valid) lat = k;
      end
      checks++; if (lat != TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO); end
      checks++; if (out_data !== 16'h7E00) begin errors++; $display("FAIL timeout_data got=%h exp=7e00", out_data); end
`ifdef SQRT_PACK_STATUS_EN
      checks++; if (status !== 3'b101) begin errors++; $display("FAIL timeout_status got=%b exp=101", status); end
`endif
      core_done = 1'b1;
      res_exp = 5'd3;
      res_mant = 10'h3;
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h7E00) begin errors++; $display("FAIL late_done_hold got=%b/%h exp=1/7e00", out_valid, out_data); end
      core_done = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_done_ignored got=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_done_at_limit();
      logic early;
      logic [15:0] exp_d;
      early = 1'b0;
      res_exp = 5'd20;
      res_mant = 10'h2F1;
      exp_d = {1'b0, 5'd20, 10'h2F1};
      drive_op(4, 1'b0, 5'd22, 10'h0F0);
      step();
      s_valid = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         core_done = (k == TO);
         step();
         if (k < TO && out_valid) early = 1'b1;
      end
      core_done = 1'b0;
      checks++; if (early) begin errors++; $display("FAIL limit_early_valid got=1 exp=0"); end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL limit_done_priority got=%b/%h exp=1/%h", out_valid, out_data, exp_d); end
`ifdef SQRT_PACK_STATUS_EN
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL limit_status got=%b exp=000", status); end
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      drive_op(4, 1'b0, 5'd18, 10'h011);
      step();
      s_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      core_done = 1'b1;
      step();
      rst = 1'b0;
      core_done = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_state got=%b%b exp=01", out_valid, in_ready); end
      checks++; if (core_exp !== 5'd0 || core_start !== 1'b0) begin errors++; $display("FAIL rst_wait_core got=%0d/%b exp=0/0", core_exp, core_start); end
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_after got=%b%b exp=01", out_valid, in_ready); end
      drive_op(2, 1'b1, 5'd31, 10'd0);
      step();
      s_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_data !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_hold got=%b/%h/%b exp=0/0000/1", out_valid, out_data, in_ready); end
   endtask

   task automatic test_random();
      int cls, j, lat, exp_lat, hold;
      logic s;
      logic [4:0] e, re;
      logic [9:0] m, rm;
      logic [15:0] exp_d;
      logic [2:0] exp_st;
      for (int it = 0; it < 40; it++) begin
         cls = int'($urandom_range(0, 5));
         s = 1'($urandom);
         e = 5'($urandom);
         m = 10'($urandom);
         re = 5'($urandom);
         rm = 10'($urandom);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_in_ready it=%0d got=%b exp=1", it, in_ready); end
         drive_op(cls, s, e, m);
         out_ready = 1'b0;
         step();
         s_valid = 1'b0;
         if (cls <= 3) begin
            exp_d = model_bypass(cls, s, e, m);
            exp_st = model_status(cls, s, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL rnd_bypass it=%0d cls=%0d got=%b/%h exp=1/%h", it, cls, out_valid, out_data, exp_d); end
         end else begin
            checks++; if (core_start !== 1'b1 || core_exp !== e || core_mant !== m || core_sub !== (cls == 5)) begin errors++; $display("FAIL rnd_launch it=%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", it, core_start, core_exp, core_mant, core_sub, e, m, cls == 5); end
            j = int'($urandom_range(1, TO + 3));
            exp_lat = (j <= TO) ? j : TO;
            exp_d = (j <= TO) ? {1'b0, re, rm} : 16'h7E00;
            exp_st = model_status(cls, s, j > TO);
            res_exp = re;
            res_mant = rm;
            lat = 0;
            for (int k = 1; k <= TO + 4 && lat == 0; k++) begin
               core_done = (k == j);
               step();
               if (out_valid) lat = k;
            end
            core_done = 1'b0;
            checks++; if (lat != exp_lat || out_data !== exp_d) begin errors++; $display("FAIL rnd_core it=%0d j=%0d got=%0d/%h exp=%0d/%h", it, j, lat, out_data, exp_lat, exp_d); end
         end
`ifdef SQRT_PACK_STATUS_EN
         checks++; if (status !== exp_st) begin errors++; $display("FAIL rnd_status it=%0d got=%b exp=%b", it, status, exp_st); end
`else
         if (exp_st === 3'bxxx) $display("unreachable");
`endif
         hold = int'($urandom_range(0, 3));
         for (int h = 0; h < hold; h++) begin
            core_done = 1'($urandom);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL rnd_hold it=%0d got=%b/%h exp=1/%h", it, out_valid, out_data, exp_d); end
         end
         core_done = 1'b0;
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rnd_release it=%0d got=%b%b exp=01", it, out_valid, in_ready); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      s_valid = 1'b0;
      is_nan = 1'b0; is_pinf = 1'b0; is_ninf = 1'b0; is_normal = 1'b0; is_subnormal = 1'b0;
      sign_in = 1'b0; exp_in = 5'd0; mant_in = 10'd0;
      core_done = 1'b0; res_exp = 5'd0; res_mant = 10'd0;
      out_ready = 1'b0;
      test_reset();
      test_pinf();
      test_neg_nan();
      test_core_and_hold();
      test_timeout();
      test_done_at_limit();
      test_rst_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sqrt_result_pack.md
SQRT_RESULT_PACK -- requirements
Module: sqrt_result_pack

Interface
REQ-001 SHALL have parameter TIMEOUT, default 47: CORE_WAIT cycle limit, 1..63.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port s_valid, input, 1: classified operand present from the special-value classifier.
REQ-005 SHALL have port in_ready, output, 1: operand accepted when s_valid && in_ready.
REQ-006 SHALL have ports is_nan, is_pinf, is_ninf, is_normal, is_subnormal, inputs, 1 each: classifier flags.
REQ-007 SHALL have ports sign_in, exp_in, mant_in, inputs, 1/5/10: classifier-adjusted FP16 fields.
REQ-008 SHALL have port core_start, output, 1: one-cycle launch pulse to the sqrt core.
REQ-009 SHALL have ports core_exp, core_mant, outputs, 5/10: operand latched for the core, stable while the core runs.
REQ-010 SHALL have port core_sub, output, 1: latched is_subnormal for the core.
REQ-011 SHALL have ports core_done, res_exp, res_mant, inputs, 1/5/10: core completion and result.
REQ-012 SHALL have ports out_valid, out_data, outputs, 1/16: packed FP16 result {sign, exp, mant}.
REQ-013 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-014 SHALL implement FSM IDLE, CORE_WAIT, OUT_HOLD; in_ready = (state==IDLE).
REQ-015 SHALL, in IDLE on accept with is_nan|is_pinf|is_ninf, load out_data = {sign_in, exp_in, mant_in} and enter OUT_HOLD.
REQ-016 SHALL, in IDLE on accept with zero operand (all five flags 0), load out_data = {sign_in, 5'd0, 10'd0} (sqrt(±0)=±0) and enter OUT_HOLD.
REQ-017 SHALL, in IDLE on accept with is_normal|is_subnormal, latch core_exp/core_mant/core_sub, pulse core_start on the next cycle only, clear the timeout counter, and enter CORE_WAIT.
REQ-018 SHALL, in CORE_WAIT, increment a 6-bit counter each cycle without core_done.
REQ-019 SHALL, on core_done in CORE_WAIT, load out_data = {1'b0, res_exp, res_mant} and enter OUT_HOLD.
REQ-020 SHALL, when the counter reaches TIMEOUT without core_done, load out_data = 16'h7E00 and enter OUT_HOLD.
REQ-021 SHALL give core_done priority over timeout in the same cycle.
REQ-022 SHALL ignore core_done outside CORE_WAIT.
REQ-023 SHALL assert out_valid exactly while in OUT_HOLD and hold out_data stable until out_valid && out_ready.
REQ-024 SHALL return to IDLE on the handshake cycle, with in_ready high the following cycle (no overlap).
REQ-025 SHALL give special/zero path latency of accept N to out_valid at N+1.
REQ-026 SHALL give core path latency of out_valid one cycle after the core_done cycle.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter IDLE from any state, including mid CORE_WAIT and OUT_HOLD, and drop any pending result.
REQ-028 SHALL, after reset, drive out_valid=0, out_data=0, core_start=0, core_exp=0, core_mant=0, core_sub=0, counter=0, in_ready=1.
REQ-029 SHALL give rst priority over every other input.

Configuration
REQ-030 SHALL, with SQRT_PACK_STATUS_EN defined, add output status[2:0] = {timeout, special, invalid}, registered with out_data and reset to 0.
REQ-031 SHALL set invalid for a NaN output whose sign_in was 1 or whose result was a timeout.
REQ-032 SHALL set special for the NaN, ±Inf and zero paths.
REQ-033 SHALL, without SQRT_PACK_STATUS_EN, omit the status port and logic and leave all other behaviour identical.

Verification
REQ-034 SHALL cover: accept {+Inf: is_pinf=1, exp=31, mant=0}, out_ready=1 -> out_valid at N+1, out_data=16'h7C00, in_ready high at N+2.
REQ-035 SHALL cover: accept negative normal (classifier gives is_nan=1, sign=1, exp=31, mant=0x200) -> out_data=16'hFE00; status=3'b011 when enabled.
REQ-036 SHALL cover: accept exp=16, mant=0; core_done after 5 cycles with res_exp=15, res_mant=0x1A8 -> core_start one cycle only, out_data=16'h3DA8 one cycle after core_done.
REQ-037 SHALL cover: core never returns -> out_data=16'h7E00 after TIMEOUT cycles; status=3'b101 when enabled; later core_done ignored.
REQ-038 SHALL cover: result held with out_ready=0 for 4 cycles -> out_data stable, in_ready=0; rst pulse mid CORE_WAIT -> IDLE, out_valid=0, in_ready=1 next cycle.
